ysyx_23060187_fetch_ctrl: RTL and testbench
===========================================

Name: ysyx_23060187_fetch_ctrl

Overview:
Multi-cycle instruction-fetch sequencer that owns the architectural PC of the ysyx_23060187 core.
- Issues one fetch per instruction to instruction memory over a valid/ready request/response handshake.
- Hands the fetched instruction to decode over valid/ready.
- Waits for the execute stage to commit the next PC, which carries the jal/jalr/branch resolution, then repeats.
- Detects fetch bus errors, misaligned targets and halts, and counts retired instructions.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 255, response wait limit; used only with FETCH_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (= pc)
imem_rsp_valid  in  1  response valid
imem_rsp_ready  out  1  controller accepts response
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  bus error on this response
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  latched instruction
inst_pc  out  32  PC of inst
commit_valid  in  1  execute reports instruction done
commit_next_pc  in  32  next PC computed by execute
commit_halt  in  1  committed instruction is ebreak/halt
pc  out  32  current PC
instret  out  64  retired instruction count
halted  out  1  sticky halt flag
fetch_err  out  1  sticky error flag
err_cause  out  2  00 none, 01 bus error, 10 misaligned target, 11 timeout

Behaviour:
- Reset (async):
  - State is IDLE.
  - pc = RESET_PC; inst, inst_pc and instret are 0.
  - All valid/ready outputs, halted, fetch_err and err_cause are 0.
- IDLE: exactly one cycle after rst deasserts, moves unconditionally to REQ.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Address is held stable while valid && !ready.
  - On imem_req_ready, moves to RSP.
- RSP:
  - imem_rsp_ready=1.
  - On imem_rsp_valid && imem_rsp_err: moves to ERR with cause 01.
  - On imem_rsp_valid && !err: latches inst <= imem_rsp_data and inst_pc <= pc, then moves to DISPATCH.
- DISPATCH:
  - inst_valid=1; inst and inst_pc are stable.
  - On inst_ready, moves to EXEC. inst_valid drops the following cycle.
- EXEC:
  - Waits for commit_valid. On commit_valid, instret increments by 1 in all three cases below.
  - If commit_halt: moves to HALT, halted=1, pc unchanged.
  - Else if commit_next_pc[1:0] != 0: moves to ERR with cause 10, pc unchanged.
  - Else: pc <= commit_next_pc and moves to REQ.
- HALT and ERR:
  - Terminal until reset; no further requests are issued.
  - halted, fetch_err and err_cause hold.
- commit_valid outside EXEC is ignored.
- imem_rsp_valid outside RSP is ignored; imem_rsp_ready=0 there.
- Zero-wait latency: 4 cycles per instruction (REQ, RSP, DISPATCH, EXEC), measured from one request to the next request.
- instret wraps modulo 2^64.
- Reset mid-transaction aborts immediately. Outputs return to reset values with no drain of an outstanding memory response; the memory model must tolerate this.
- States are one-hot or binary; encoding is free. No combinational path from inputs to imem_req_valid or inst_valid.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RSP and increments each RSP cycle without imem_rsp_valid.
  - When it reaches TIMEOUT_CYCLES, the controller moves to ERR with cause 11.
  - A response arriving in the same cycle as the limit wins.
- Undefined: RSP waits indefinitely, the counter is not instantiated, and cause 11 never occurs.

Decomposition:
- Shared package ysyx_23060187_fetch_pkg holds:
  - state encodings (IDLE, REQ, RSP, DISPATCH, EXEC, HALT, ERR);
  - err_cause codes (ERR_NONE, ERR_BUS, ERR_MISALIGN, ERR_TIMEOUT);
  - default RESET_PC.
- One natural sub-module: ysyx_23060187_fetch_timer, the timeout counter, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset release:
  - After rst deasserts, wait 1 cycle, then imem_req_valid=1 with addr 0x8000_0000.
  - pc=0x8000_0000, instret=0.
- Zero-wait stream with always-ready memory and decode:
  - Commits of next_pc 0x8000_0004, then 0x8000_0008, give requests exactly 4 cycles apart at those addresses.
  - instret=2.
- Backpressure:
  - Hold imem_req_ready=0 for 3 cycles and inst_ready=0 for 2 cycles.
  - Address, inst and inst_pc stay stable.
  - No duplicate request; one instret increment per commit.
- Errors and halt:
  - Response with err=1 gives fetch_err=1, cause 01, and no further requests.
  - commit_next_pc 0x8000_0102 gives cause 10, with pc still at the old value.
  - commit_halt=1 gives halted=1 and instret incremented.
- Reset mid-RSP and spurious commit:
  - Asserting rst while waiting for a response immediately zeroes outputs.
  - The next request goes to 0x8000_0000.
  - commit_valid pulsed in REQ does not change pc.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8:
  - No response for 8 RSP cycles gives cause 11.
  - A response on cycle 8 is accepted instead.

Source files
------------

// File: rtl/ysyx_23060187_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_fetch_pkg
// Shared constants for the instruction-fetch sequencer: FSM state codes,
// err_cause codes and the default reset PC.
// No ports (package).
// ----------------------------------------------------------------------------
package ysyx_23060187_fetch_pkg;

    // FSM state codes (binary encoded)
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_RSP      = 3'd2;
    localparam logic [2:0] S_DISPATCH = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    // err_cause codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060187_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_fetch_ctrl_if
// Bundles the fetch controller's two handshakes:
//   - instruction-memory request/response (valid/ready, data, err)
//   - instruction hand-off to decode (valid/ready, inst, inst_pc)
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid && ready are both 1; once valid is raised, the payload stays
// stable until that transfer.
// Modports:
//   master - the fetch controller
//   slave  - the memory and decode side
// ----------------------------------------------------------------------------
interface ysyx_23060187_fetch_ctrl_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
        output inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
        input  inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_ready
    );

endinterface

// File: rtl/ysyx_23060187_fetch_ctrl_timer.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_fetch_timer
// Response-wait counter, only instantiated when FETCH_TIMEOUT_EN is defined.
// Ports:
//   clk, rst     clock, async active-high reset
//   clear_i      request accepted (next cycle is the first RSP cycle)
//   tick_i       an RSP cycle without imem_rsp_valid
//   expired_o    this waiting cycle is the TIMEOUT_CYCLES-th one
// ----------------------------------------------------------------------------
module ysyx_23060187_fetch_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (tick_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // cnt_q counts earlier waiting cycles, so the limit is hit while the
    // current cycle is also waiting; a response this cycle clears tick_i.
    assign expired_o = tick_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ysyx_23060187_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_fetch_ctrl
// Multi-cycle fetch sequencer owning the architectural PC:
//   IDLE -> REQ -> RSP -> DISPATCH -> EXEC -> REQ ...  (HALT/ERR terminal)
// Optional feature macro: FETCH_TIMEOUT_EN (response-wait timeout, cause 11).
// Ports:
//   clk, rst        clock, async active-high reset
//   bus (master)    imem request/response and decode hand-off
//   commit_*        next-PC / halt report from execute
//   pc, instret     architectural PC and retired-instruction count
//   halted          sticky halt flag
//   fetch_err       sticky error flag, err_cause gives the reason
//   dbg_state_o     current FSM state
// ----------------------------------------------------------------------------
module ysyx_23060187_fetch_ctrl
    import ysyx_23060187_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_23060187_fetch_ctrl_if.master   bus,
    input  logic                         commit_valid,
    input  logic [31:0]                  commit_next_pc,
    input  logic                         commit_halt,
    output logic [31:0]                  pc,
    output logic [63:0]                  instret,
    output logic                         halted,
    output logic                         fetch_err,
    output logic [1:0]                   err_cause,
    output logic [2:0]                   dbg_state_o
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [63:0] instret_q, instret_d;
    logic        halted_q, halted_d;
    logic        fetch_err_q, fetch_err_d;
    logic [1:0]  err_cause_q, err_cause_d;
    logic        rsp_timeout;

`ifdef FETCH_TIMEOUT_EN
    ysyx_23060187_fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   ((state_q == S_REQ) && bus.imem_req_ready),
        .tick_i    ((state_q == S_RSP) && !bus.imem_rsp_valid),
        .expired_o (rsp_timeout)
    );
`else
    // No timer in this build: RSP waits forever. The limit is never
    // negative, so this ties the timeout off while keeping the parameter.
    assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        instret_d   = instret_q;
        halted_d    = halted_q;
        fetch_err_d = fetch_err_q;
        err_cause_d = err_cause_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready) state_d = S_RSP;
            end
            S_RSP: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.imem_rsp_err) begin
                        state_d     = S_ERR;
                        fetch_err_d = 1'b1;
                        err_cause_d = ERR_BUS;
                    end else begin
                        inst_d    = bus.imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_DISPATCH;
                    end
                end else if (rsp_timeout) begin
                    state_d     = S_ERR;
                    fetch_err_d = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                end
            end
            S_DISPATCH: begin
                if (bus.inst_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (commit_valid) begin
                    // Halt and misaligned commits still retire.
                    instret_d = instret_q + 64'd1;
                    if (commit_halt) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (commit_next_pc[1:0] != 2'b00) begin
                        state_d     = S_ERR;
                        fetch_err_d = 1'b1;
                        err_cause_d = ERR_MISALIGN;
                    end else begin
                        pc_d    = commit_next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            default: ;  // HALT, ERR and unused codes: terminal until reset
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            instret_q   <= '0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            instret_q   <= instret_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
            err_cause_q <= err_cause_d;
        end
    end

    // Handshake outputs decode only the state register.
    assign bus.imem_req_valid = (state_q == S_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.imem_rsp_ready = (state_q == S_RSP);
    assign bus.inst_valid     = (state_q == S_DISPATCH);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;

    assign pc          = pc_q;
    assign instret     = instret_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;
    assign err_cause   = err_cause_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_23060187_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060187_fetch_ctrl
// Directed bench for the fetch sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Timeout scenarios are compiled in only with FETCH_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_ysyx_23060187_fetch_ctrl;
    import ysyx_23060187_fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060187_fetch_ctrl_if bus();

    logic        commit_valid;
    logic [31:0] commit_next_pc;
    logic        commit_halt;
    logic [31:0] pc;
    logic [63:0] instret;
    logic        halted;
    logic        fetch_err;
    logic [1:0]  err_cause;
    logic [2:0]  dbg_state;

    ysyx_23060187_fetch_ctrl #(
        .RESET_PC       (32'h8000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .commit_valid   (commit_valid),
        .commit_next_pc (commit_next_pc),
        .commit_halt    (commit_halt),
        .pc             (pc),
        .instret        (instret),
        .halted         (halted),
        .fetch_err      (fetch_err),
        .err_cause      (err_cause),
        .dbg_state_o    (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();  // IDLE -> REQ on this edge
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        commit_valid       = 1'b0;
        commit_next_pc     = '0;
        commit_halt        = 1'b0;

        // Reset values
        repeat (2) step();
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_rsp_ready", bus.imem_rsp_ready, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_instret", instret, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_flags", {halted, fetch_err, err_cause}, 0);

        // Release: one IDLE cycle, then the first request
        rst = 1'b0;
        chk("rel_idle", bus.imem_req_valid, 0);
        step();
        chk("rel_req_valid", bus.imem_req_valid, 1);
        chk("rel_req_addr", bus.imem_req_addr, 32'h8000_0000);

        // Zero-wait stream; commit_valid also held high through REQ
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        bus.inst_ready     = 1'b1;
        commit_valid       = 1'b1;
        commit_next_pc     = 32'h8000_0004;
        step();
        chk("zw_rsp_state", dbg_state, S_RSP);
        chk("zw_rsp_ready", bus.imem_rsp_ready, 1);
        chk("zw_spurious_pc", pc, 32'h8000_0000);
        step();
        chk("zw_inst_valid", bus.inst_valid, 1);
        chk("zw_inst", bus.inst, 32'h0000_0013);
        chk("zw_inst_pc", bus.inst_pc, 32'h8000_0000);
        step();
        chk("zw_exec_state", dbg_state, S_EXEC);
        chk("zw_exec_req_low", bus.imem_req_valid, 0);
        step();
        chk("zw_req2_valid", bus.imem_req_valid, 1);
        chk("zw_req2_addr", bus.imem_req_addr, 32'h8000_0004);
        chk("zw_instret1", instret, 1);
        commit_next_pc    = 32'h8000_0008;
        bus.imem_rsp_data = 32'h0010_0093;
        step();
        step();
        chk("zw_inst2", bus.inst, 32'h0010_0093);
        chk("zw_inst_pc2", bus.inst_pc, 32'h8000_0004);
        step();
        chk("zw_gap_req_low", bus.imem_req_valid, 0);
        step();
        chk("zw_req3_valid", bus.imem_req_valid, 1);
        chk("zw_req3_addr", bus.imem_req_addr, 32'h8000_0008);
        chk("zw_instret2", instret, 2);

        // Backpressure: req_ready low 3 cycles, inst_ready low 2 cycles
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        bus.inst_ready     = 1'b0;
        commit_valid       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_req_hold_valid", bus.imem_req_valid, 1);
            chk("bp_req_hold_addr", bus.imem_req_addr, 32'h8000_0008);
        end
        bus.imem_req_ready = 1'b1;
        step();
        chk("bp_rsp_state", dbg_state, S_RSP);
        chk("bp_no_dup_req", bus.imem_req_valid, 0);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("bp_inst_valid", bus.inst_valid, 1);
        chk("bp_inst", bus.inst, 32'hDEAD_BEEF);
        chk("bp_inst_pc", bus.inst_pc, 32'h8000_0008);
        step();
        chk("bp_inst_hold_valid", bus.inst_valid, 1);
        chk("bp_inst_hold", bus.inst, 32'hDEAD_BEEF);
        chk("bp_inst_pc_hold", bus.inst_pc, 32'h8000_0008);
        chk("bp_no_req_disp", bus.imem_req_valid, 0);
        bus.inst_ready = 1'b1;
        step();
        chk("bp_exec_state", dbg_state, S_EXEC);
        chk("bp_inst_valid_drop", bus.inst_valid, 0);
        commit_valid   = 1'b1;
        commit_next_pc = 32'h8000_000C;
        step();
        commit_valid = 1'b0;
        chk("bp_instret3", instret, 3);
        chk("bp_req_addr", bus.imem_req_addr, 32'h8000_000C);
        step();
        chk("bp_instret_once", instret, 3);

        // Misaligned commit target
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        repeat (3) step();
        chk("mis_exec_state", dbg_state, S_EXEC);
        commit_valid   = 1'b1;
        commit_next_pc = 32'h8000_0102;
        step();
        commit_valid = 1'b0;
        chk("mis_state", dbg_state, S_ERR);
        chk("mis_fetch_err", fetch_err, 1);
        chk("mis_cause", err_cause, ERR_MISALIGN);
        chk("mis_pc_kept", pc, 32'h8000_000C);
        chk("mis_instret", instret, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mis_no_req", bus.imem_req_valid, 0);
            chk("mis_cause_hold", err_cause, ERR_MISALIGN);
        end

        // Reset out of ERR, spurious commit in REQ, reset mid-RSP
        bus.imem_rsp_valid = 1'b0;
        do_reset();
        chk("r2_req_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("r2_instret", instret, 0);
        chk("r2_flags", {halted, fetch_err, err_cause}, 0);
        bus.imem_req_ready = 1'b0;
        commit_valid       = 1'b1;
        commit_next_pc     = 32'h8000_0040;
        step();
        commit_valid = 1'b0;
        chk("spur_pc", pc, 32'h8000_0000);
        chk("spur_instret", instret, 0);
        chk("spur_state", dbg_state, S_REQ);
        bus.imem_req_ready = 1'b1;
        step();
        chk("mid_rsp_ready", bus.imem_rsp_ready, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rsp_ready", bus.imem_rsp_ready, 0);
        chk("mid_rst_req_valid", bus.imem_req_valid, 0);
        chk("mid_rst_state", dbg_state, S_IDLE);
        step();
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b1;
        step();
        chk("mid_next_req_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("mid_next_req_valid", bus.imem_req_valid, 1);

        // Bus error on the response
        step();
        step();
        chk("bus_state", dbg_state, S_ERR);
        chk("bus_fetch_err", fetch_err, 1);
        chk("bus_cause", err_cause, ERR_BUS);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bus_no_req", bus.imem_req_valid, 0);
        end

        // Halt
        do_reset();
        bus.imem_rsp_valid = 1'b1;
        repeat (3) step();
        chk("halt_exec_state", dbg_state, S_EXEC);
        commit_valid   = 1'b1;
        commit_halt    = 1'b1;
        commit_next_pc = 32'h8000_0004;
        step();
        commit_valid = 1'b0;
        commit_halt  = 1'b0;
        chk("halt_state", dbg_state, S_HALT);
        chk("halt_flag", halted, 1);
        chk("halt_instret", instret, 1);
        chk("halt_pc", pc, 32'h8000_0000);
        chk("halt_no_err", fetch_err, 0);
        step();
        chk("halt_no_req", bus.imem_req_valid, 0);
        chk("halt_hold", halted, 1);

`ifdef FETCH_TIMEOUT_EN
        // No response for 8 RSP cycles -> timeout
        bus.imem_rsp_valid = 1'b0;
        do_reset();
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_still_rsp", dbg_state, S_RSP);
        end
        step();
        chk("to_state", dbg_state, S_ERR);
        chk("to_cause", err_cause, ERR_TIMEOUT);
        chk("to_fetch_err", fetch_err, 1);

        // Response on the 8th RSP cycle wins
        do_reset();
        step();
        repeat (7) step();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("to_last_state", dbg_state, S_DISPATCH);
        chk("to_last_inst", bus.inst, 32'h1234_5678);
        chk("to_last_no_err", fetch_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
